// File: rtl/fifo_stream_reader_pkg.sv
// fifo_pkg: shared constants, reader state encoding and width helper
package fifo_pkg;
    localparam int FIFO_WIDTH_DEF = 32;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_state_t;
    function automatic int beat_cnt_w(input int burst_len);
        return $clog2(burst_len + 1);
    endfunction
endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: FIFO read port plus valid/ready output stream
interface fifo_stream_reader_if
    import fifo_pkg::*;
#(
    parameter int W = FIFO_WIDTH_DEF
);
    logic         fifo_empty;
    logic [W-1:0] fifo_data_out;
    logic         fifo_rd_en;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic         m_last;
    modport master (
        input  fifo_empty, fifo_data_out, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last
    );
    modport slave (
        output fifo_empty, fifo_data_out, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fifo_stream_reader_skid_buf.sv
// stream_skid_buf: 2-entry registered FIFO-ordered buffer with head on m_data
module stream_skid_buf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] d_in,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data,
    output logic [1:0]   count
);
    logic [W-1:0] d1;
    logic         pop;
    assign m_valid = count != 2'd0;
    assign pop     = m_valid & m_ready;
    // head advances on pop, tail slot fills when a push lands behind a held head
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            m_data <= '0;
            d1     <= '0;
        end else begin
            if (pop)
                m_data <= count == 2'd2 ? d1 : push ? d_in : m_data;
            else if (push && count == 2'd0)
                m_data <= d_in;
            if (push && (pop ? count == 2'd2 : count == 2'd1))
                d1 <= d_in;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a show-ahead FIFO into a burst-framed valid/ready stream
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int BURST_LEN  = 4,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    fifo_stream_reader_if.master bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     words_sent
);
    localparam int BW = beat_cnt_w(BURST_LEN);
    rd_state_t     state;
    logic [BW-1:0] beat_cnt;
    logic [1:0]    buf_count;
    logic          accept;
    logic          at_last;
    assign bus.fifo_rd_en = enable & ~bus.fifo_empty & (buf_count < 2'd2) & ~rst;
    assign accept         = bus.m_valid & bus.m_ready;
    assign at_last        = beat_cnt == BW'(BURST_LEN - 1);
    assign bus.m_last     = at_last & bus.m_valid;
    assign busy           = state != IDLE;
    stream_skid_buf #(.W(FIFO_WIDTH)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .push    (bus.fifo_rd_en),
        .d_in    (bus.fifo_data_out),
        .m_valid (bus.m_valid),
        .m_ready (bus.m_ready),
        .m_data  (bus.m_data),
        .count   (buf_count)
    );
    // run/drain control, burst position and delivered-beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            words_sent <= '0;
        end else begin
            state <= state == IDLE ? (enable ? RUN : IDLE)
                   : state == RUN  ? (enable ? RUN : buf_count != 2'd0 ? DRAIN : IDLE)
                   :                 (enable ? RUN : buf_count == 2'd0 ? IDLE : DRAIN);
            if (accept) begin
                beat_cnt   <= at_last ? '0 : beat_cnt + 1'b1;
                words_sent <= words_sent + 1'b1;
            end
        end
    end
endmodule
